// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the fetch stage and its bench.
// Contents: instruction width, the NOP encoding driven on fetch faults,
// R-type opcode/funct codes and a helper that assembles an R-type word.
package mips_pkg;

  localparam int INSTR_W = 32;

  // sll $0,$0,0 encodes as all zeros and is the canonical MIPS NOP.
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;

  // Assemble an R-type instruction: opcode | rs | rt | rd | shamt=0 | funct.
  function automatic logic [INSTR_W-1:0] mk_rtype(input logic [4:0] rs,
                                                  input logic [4:0] rt,
                                                  input logic [4:0] rd,
                                                  input logic [5:0] funct);
    return {OP_RTYPE, rs, rt, rd, 5'd0, funct};
  endfunction

endpackage

// File: rtl/mem_instr_array.sv
// Instruction storage: DEPTH x DATA_W words, one synchronous write port and
// one asynchronous read port. Ports: clock, we/waddr/wdata (write),
// raddr/rdata (read). Not reset; contents survive a core reset.
module mem_instr_array
  import mips_pkg::*;
#(
  parameter int DATA_W = INSTR_W,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam logic [IDX_W:0] DEPTH_X = (IDX_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  // When DEPTH is not a power of two the index field can name words that do
  // not exist; such writes are dropped and such reads return zero.
  always_ff @(posedge clock) begin
    if (we && ({1'b0, waddr} < DEPTH_X)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = ({1'b0, raddr} < DEPTH_X) ? mem[raddr] : '0;

endmodule

// File: rtl/memoria_instrucoes_sync.sv
// Synchronous instruction memory for the MIPS fetch stage, between the PC
// register and IF/ID. One-cycle fetch latency with valid and fault flags.
// Ports: clock, reset (async, active-high); fetch_req/stall/pc in;
// instrucao/instr_valid/fora_limite/desalinhado out; load_en/load_addr/
// load_data program-load port; load_count = saturating count of loads.
module memoria_instrucoes_sync
  import mips_pkg::*;
#(
  parameter int DATA_W   = INSTR_W,
  parameter int ADDR_W   = 32,
  parameter int DEPTH    = 16,
  parameter int BYTE_ADR = 1,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_INSTR)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     fetch_req,
  input  logic                     stall,
  input  logic [ADDR_W-1:0]        pc,
  output logic [DATA_W-1:0]        instrucao,
  output logic                     instr_valid,
  output logic                     fora_limite,
  output logic                     desalinhado,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [DATA_W-1:0]        load_data,
  output logic [$clog2(DEPTH):0]   load_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] idx;
  logic              mis;
  logic              oob;
  logic              accept;
  logic [DATA_W-1:0] rd_data;

  generate
    if (BYTE_ADR != 0) begin : g_byte_adr
      assign idx = {2'b00, pc[ADDR_W-1:2]};
      assign mis = |pc[1:0];
    end else begin : g_word_adr
      assign idx = pc;
      assign mis = 1'b0;
    end
  endgenerate

  // Full-width compare: high PC bits must not alias back into the array.
  assign oob = (idx >= DEPTH_A);

  // A load owns the cycle; a fetch presented alongside it is not accepted.
  assign accept = fetch_req & ~stall & ~load_en;

  mem_instr_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clock (clock),
    .we    (load_en),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (idx[IDX_W-1:0]),
    .rdata (rd_data)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instrucao   <= '0;
      instr_valid <= 1'b0;
      fora_limite <= 1'b0;
      desalinhado <= 1'b0;
      load_count  <= '0;
    end else begin
      // Stall freezes the whole output bundle; otherwise a non-accepted
      // cycle only drops valid and leaves data and flags as they were.
      if (!stall) begin
        if (accept) begin
          instrucao   <= (mis || oob) ? NOP_WORD : rd_data;
          instr_valid <= 1'b1;
          fora_limite <= oob;
          desalinhado <= mis;
        end else begin
          instr_valid <= 1'b0;
        end
      end
      // Discarded out-of-range loads still count.
      if (load_en && (load_count != DEPTH_C)) begin
        load_count <= load_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_memoria_instrucoes_sync.sv
module tb_memoria_instrucoes_sync;
  import mips_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // DUT A: DEPTH=16, byte addressed
  logic        a_req, a_stall, a_load;
  logic [31:0] a_pc, a_ldata, a_instr;
  logic [3:0]  a_laddr;
  logic        a_valid, a_oob, a_mis;
  logic [4:0]  a_cnt;

  // DUT B: DEPTH=12, word addressed
  logic        b_req, b_stall, b_load;
  logic [31:0] b_pc, b_ldata, b_instr;
  logic [3:0]  b_laddr;
  logic        b_valid, b_oob, b_mis;
  logic [4:0]  b_cnt;

  memoria_instrucoes_sync #(.DATA_W(32), .ADDR_W(32), .DEPTH(16), .BYTE_ADR(1)) dut_a (
    .clock(clock), .reset(reset), .fetch_req(a_req), .stall(a_stall), .pc(a_pc),
    .instrucao(a_instr), .instr_valid(a_valid), .fora_limite(a_oob), .desalinhado(a_mis),
    .load_en(a_load), .load_addr(a_laddr), .load_data(a_ldata), .load_count(a_cnt));

  memoria_instrucoes_sync #(.DATA_W(32), .ADDR_W(32), .DEPTH(12), .BYTE_ADR(0)) dut_b (
    .clock(clock), .reset(reset), .fetch_req(b_req), .stall(b_stall), .pc(b_pc),
    .instrucao(b_instr), .instr_valid(b_valid), .fora_limite(b_oob), .desalinhado(b_mis),
    .load_en(b_load), .load_addr(b_laddr), .load_data(b_ldata), .load_count(b_cnt));

  // Reference model: memory contents and expected output bundle per DUT.
  logic [31:0] ma [16];
  logic [31:0] mb [12];
  logic [31:0] ea_instr, eb_instr;
  logic        ea_v, ea_oob, ea_mis, eb_v, eb_oob, eb_mis;
  int          ea_cnt, eb_cnt;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ea_instr = '0; ea_v = 0; ea_oob = 0; ea_mis = 0; ea_cnt = 0;
    eb_instr = '0; eb_v = 0; eb_oob = 0; eb_mis = 0; eb_cnt = 0;
  endtask

  // One clock of the behavioural rules for both memories.
  task automatic model_step();
    int widx;
    if (a_load) begin
      ma[a_laddr] = a_ldata;
      if (ea_cnt < 16) ea_cnt++;
    end
    if (!a_stall) begin
      if (a_req && !a_load) begin
        widx   = int'(a_pc / 4);
        ea_mis = (a_pc % 4) != 0;
        ea_oob = (a_pc / 4) >= 16;
        if (ea_mis || ea_oob) ea_instr = 32'h0;
        else                  ea_instr = ma[widx];
        ea_v = 1;
      end else begin
        ea_v = 0;
      end
    end
    if (b_load) begin
      if (b_laddr < 12) mb[b_laddr] = b_ldata;
      if (eb_cnt < 12) eb_cnt++;
    end
    if (!b_stall) begin
      if (b_req && !b_load) begin
        eb_mis = 0;
        eb_oob = b_pc >= 12;
        if (eb_oob) eb_instr = 32'h0;
        else        eb_instr = mb[int'(b_pc)];
        eb_v = 1;
      end else begin
        eb_v = 0;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_a(input string tag);
    chk({tag, ".a.instr"}, a_instr, ea_instr);
    chk({tag, ".a.valid"}, {31'b0, a_valid}, {31'b0, ea_v});
    chk({tag, ".a.fora"},  {31'b0, a_oob},   {31'b0, ea_oob});
    chk({tag, ".a.desal"}, {31'b0, a_mis},   {31'b0, ea_mis});
    chk({tag, ".a.count"}, {27'b0, a_cnt},   32'(ea_cnt));
  endtask

  task automatic check_b(input string tag);
    chk({tag, ".b.instr"}, b_instr, eb_instr);
    chk({tag, ".b.valid"}, {31'b0, b_valid}, {31'b0, eb_v});
    chk({tag, ".b.fora"},  {31'b0, b_oob},   {31'b0, eb_oob});
    chk({tag, ".b.desal"}, {31'b0, b_mis},   {31'b0, eb_mis});
    chk({tag, ".b.count"}, {27'b0, b_cnt},   32'(eb_cnt));
  endtask

  initial begin
    reset = 1'b1;
    a_req = 0; a_stall = 0; a_load = 0; a_pc = '0; a_laddr = '0; a_ldata = '0;
    b_req = 0; b_stall = 0; b_load = 0; b_pc = '0; b_laddr = '0; b_ldata = '0;
    for (int i = 0; i < 16; i++) ma[i] = '0;
    for (int i = 0; i < 12; i++) mb[i] = '0;
    model_reset();
    #12;
    check_a("reset"); check_b("reset");
    reset = 1'b0;
    tick(); check_a("idle0");

    // Program load and first fetches
    a_load = 1; a_laddr = 4'd0; a_ldata = mk_rtype(5'd16, 5'd17, 5'd8, FN_ADD);
    tick(); check_a("load0");
    a_laddr = 4'd3; a_ldata = mk_rtype(5'd17, 5'd16, 5'd8, FN_SUB);
    tick(); check_a("load3");
    a_load = 0; a_req = 1; a_pc = 32'd0;
    tick(); check_a("fetch0");
    chk("fetch0.lit", a_instr, 32'h02114020);
    a_pc = 32'd12;
    tick(); check_a("fetch12");
    chk("fetch12.lit", a_instr, 32'h02304022);

    // Load and fetch in the same cycle: load wins, valid drops
    a_load = 1; a_laddr = 4'd5; a_ldata = $urandom; a_pc = 32'd0;
    tick(); check_a("ldfetch");
    chk("ldfetch.valid.lit", {31'b0, a_valid}, 32'd0);
    chk("ldfetch.count.lit", {27'b0, a_cnt}, 32'd3);

    // 17 more loads -> 20 total, count saturates at 16
    a_req = 0;
    for (int i = 1; i <= 17; i++) begin
      a_laddr = 4'(i % 16); a_ldata = $urandom;
      tick();
    end
    check_a("sat");
    chk("sat.count.lit", {27'b0, a_cnt}, 32'd16);

    // Range / alignment faults
    a_load = 0; a_req = 1;
    a_pc = 32'd60; tick(); check_a("pc60");
    a_pc = 32'd64; tick(); check_a("pc64");
    chk("pc64.fora.lit", {31'b0, a_oob}, 32'd1);
    chk("pc64.instr.lit", a_instr, 32'h0);
    a_pc = 32'd6;  tick(); check_a("pc6");
    chk("pc6.desal.lit", {31'b0, a_mis}, 32'd1);
    a_pc = 32'd66; tick(); check_a("pc66");
    a_pc = 32'hFFFF_FFF0; tick(); check_a("pchigh");
    a_pc = 32'd8;  tick(); check_a("prestall");

    // Stall for three cycles while pc moves: outputs frozen
    a_stall = 1;
    for (int k = 0; k < 3; k++) begin
      a_pc = 32'(4 * k + 20);
      tick(); check_a("stall");
    end
    a_stall = 0; a_req = 0;
    tick(); check_a("idle_after_stall");

    // DUT B: out-of-range load, fill, word-addressed fetches
    b_load = 1; b_laddr = 4'd13; b_ldata = $urandom;
    tick(); check_b("b_ld13");
    for (int i = 0; i < 12; i++) begin
      b_laddr = 4'(i); b_ldata = $urandom;
      tick();
    end
    check_b("b_fill");
    b_load = 0; b_req = 1;
    b_pc = 32'd6;  tick(); check_b("b_pc6");
    b_pc = 32'd11; tick(); check_b("b_pc11");
    b_pc = 32'd12; tick(); check_b("b_pc12");
    b_pc = 32'd13; tick(); check_b("b_pc13");
    b_req = 0;
    tick(); check_b("b_idle");

    // Randomized traffic on both memories
    for (int n = 0; n < 300; n++) begin
      a_stall = ($urandom_range(0, 4) == 0);
      a_load  = !a_stall && ($urandom_range(0, 6) == 0);
      a_req   = ($urandom_range(0, 9) < 7);
      a_pc    = 32'($urandom_range(0, 80));
      a_laddr = 4'($urandom_range(0, 15));
      a_ldata = $urandom;
      b_stall = ($urandom_range(0, 4) == 0);
      b_load  = !b_stall && ($urandom_range(0, 6) == 0);
      b_req   = ($urandom_range(0, 9) < 7);
      b_pc    = 32'($urandom_range(0, 15));
      b_laddr = 4'($urandom_range(0, 15));
      b_ldata = $urandom;
      tick(); check_a("rand"); check_b("rand");
    end

    // Reset between edges with requests pending
    a_stall = 0; a_load = 0; a_req = 1; a_pc = 32'd8;
    b_stall = 0; b_load = 0; b_req = 1; b_pc = 32'd3;
    tick(); check_a("pre_rst"); check_b("pre_rst");
    #3 reset = 1'b1;
    #1;
    model_reset();
    check_a("rst_mid"); check_b("rst_mid");
    #1 reset = 1'b0;
    tick(); check_a("post_rst"); check_b("post_rst");
    chk("post_rst.valid.lit", {31'b0, a_valid}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
